addsub_seq: RTL
===============

ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 SHALL have parameter W, default 16, meaning total operand/result width in bits; W SHALL be a multiple of N.
REQ-002 SHALL have parameter N, default 4, meaning width of the shared add/sub slice, i.e. bits processed per cycle.
REQ-003 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-004 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: start  in  1  request to begin an operation; sampled only in IDLE or DONE.
REQ-006 SHALL have ports: op  in  1  0 = add, 1 = subtract (b inverted before the slice).
REQ-007 SHALL have ports: ci  in  1  carry-in to the least significant slice; subtract requires ci=1 for two's complement.
REQ-008 SHALL have ports: a, b  in  W  operands, sampled on the accepting edge only.
REQ-009 SHALL have ports: result  out  W  registered sum/difference.
REQ-010 SHALL have ports: cout  out  1  carry out of bit W-1.
REQ-011 SHALL have ports: ovf  out  1  signed overflow of the full-width operation.
REQ-012 SHALL have ports: busy  out  1  high while an operation is in progress.
REQ-013 SHALL have ports: done  out  1  one-cycle pulse when result/cout/ovf become valid.

Function
REQ-014 SHALL compute result = (a + (op ? ~b : b) + ci) mod 2^W, and cout = bit W of that sum.
REQ-015 SHALL compute ovf = (a[W-1] == b'[W-1]) && (result[W-1] != a[W-1]), with b' = op ? ~b : b.
REQ-016 SHALL use exactly one N-bit add/sub slice, time-shared across W/N cycles, LSB slice first; the inter-slice carry is held in a carry register.
REQ-017 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-018 IDLE: start=1 latches a, b, op and ci, clears the slice index to 0 and moves to RUN; start=0 stays in IDLE.
REQ-019 RUN: each edge writes result slice[idx] and the carry register and increments idx; the edge at idx = W/N-1 moves to DONE.
REQ-020 DONE: done=1 for exactly this one cycle; start=1 is accepted here exactly as in IDLE (back-to-back operation), otherwise the FSM moves to IDLE.
REQ-021 Latency SHALL be W/N edges from the accepting edge to the edge after which done=1 (4 for the defaults).
REQ-022 busy SHALL be 1 exactly while in RUN.
REQ-023 start SHALL be ignored while busy=1; latched operands SHALL NOT change while in RUN.
REQ-024 result, cout and ovf SHALL hold their values from DONE until the next accepting edge; on that edge result SHALL be cleared to 0.
REQ-025 cout SHALL equal the carry register after the final slice.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE and set result=0, cout=0, ovf=0, busy=0, done=0, idx=0 and carry register=0.
REQ-027 rst asserted mid-RUN SHALL abort the operation with no done pulse; rst SHALL take priority over start.

Structure
REQ-028 The FSM state encoding and the default W/N constants SHALL live in a shared package, addsub_pkg.
REQ-029 The N-bit slice SHALL be a separate sub-module, addsub_slice, with inputs x, y, k, ci and outputs s, cu, and behaviour s = x + (k ? ~y : y) + ci.
REQ-030 The controller SHALL contain no second adder; ovf SHALL be derived from latched sign bits and the final result.

Verification
REQ-031 Add: a=0x1234, b=0x1111, op=0, ci=0 -> result=0x2345, cout=0, ovf=0; done exactly 4 edges after acceptance; busy high for 4 cycles.
REQ-032 Subtract: a=0x0005, b=0x0003, op=1, ci=1 -> result=0x0002, cout=1, ovf=0.
REQ-033 Full carry chain: a=0xFFFF, b=0x0001, op=0, ci=0 -> result=0x0000, cout=1, ovf=0. Signed overflow: a=0x7FFF, b=0x0001 -> result=0x8000, cout=0, ovf=1.
REQ-034 start pulsed with different operands during RUN -> ignored; the original result completes unchanged.
REQ-035 rst=1 on the 2nd RUN edge -> all outputs 0, no done pulse, FSM in IDLE; the next start with a=0x0001, b=0x0001 -> result=0x0002.
REQ-036 start=1 held in the DONE cycle with new operands -> the new operation is accepted with no IDLE cycle; two done pulses are spaced 5 cycles apart.

Source files
------------

// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_pkg
//  Purpose  : Shared constants for the slice-serial adder/subtractor:
//             default operand and slice widths, controller state encoding,
//             and a helper that sizes the slice index register.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package addsub_pkg;

    localparam int c_DEF_W = 16;
    localparam int c_DEF_N = 4;

    // Controller state encoding
    localparam int         c_ST_W    = 2;
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // A single-slice configuration still needs a 1-bit index register.
    function automatic int idx_width(input int slices);
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_slice.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_slice
//  Purpose  : N-bit add/subtract slice, s = x + (k ? ~y : y) + ci.
//  Ports    : x  [N-1:0] in  - first operand slice
//             y  [N-1:0] in  - second operand slice (inverted when k=1)
//             k          in  - 1 selects subtract (invert y)
//             ci         in  - carry into the slice
//             s  [N-1:0] out - slice sum
//             cu         out - carry out of the slice
//  Revision : 1.0 - initial release
// ============================================================================
module addsub_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         k,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         cu
);

    logic [N-1:0] w_y;

    assign w_y = k ? ~y : y;

    // One extra bit on each term captures the carry out of the slice.
    assign {cu, s} = {1'b0, x} + {1'b0, w_y} + {{N{1'b0}}, ci};

endmodule
`default_nettype wire

// File: rtl/addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_seq
//  Purpose  : Slice-serial W-bit adder/subtractor. A single N-bit slice is
//             reused over W/N cycles, least significant slice first, with
//             the inter-slice carry held in a register.
//  Ports    : clk            in  - clock, rising edge
//             rst            in  - synchronous active-high reset
//             start          in  - begin operation (sampled in IDLE/DONE)
//             op             in  - 0 = add, 1 = subtract
//             ci             in  - carry into the least significant slice
//             a, b   [W-1:0] in  - operands, captured on the accepting edge
//             result [W-1:0] out - registered sum/difference
//             cout           out - carry out of bit W-1
//             ovf            out - signed overflow
//             busy           out - high while the operation is running
//             done           out - one-cycle pulse when outputs are valid
//  Revision : 1.0 - initial release
// ============================================================================
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int W = c_DEF_W,
    parameter int N = c_DEF_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op,
    input  logic         ci,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         ovf,
    output logic         busy,
    output logic         done
);

    localparam int              c_NSL  = W / N;
    localparam int              c_IW   = idx_width(c_NSL);
    localparam logic [c_IW-1:0] c_LAST = c_IW'(c_NSL - 1);

    logic [c_ST_W-1:0]       r_state;
    logic [c_NSL-1:0][N-1:0] r_a;
    logic [c_NSL-1:0][N-1:0] r_b;
    logic [c_NSL-1:0][N-1:0] r_result;
    logic                    r_op;
    logic                    r_carry;
    logic [c_IW-1:0]         r_idx;
    logic                    r_cout;
    logic                    r_ovf;
    logic                    r_busy;
    logic                    r_done;

    logic [N-1:0]            w_s;
    logic                    w_cu;
    logic                    w_last;
    logic                    w_a_sign;
    logic                    w_b_sign;
    logic                    w_ovf;

    addsub_slice #(
        .N (N)
    ) u_slice (
        .x  (r_a[r_idx]),
        .y  (r_b[r_idx]),
        .k  (r_op),
        .ci (r_carry),
        .s  (w_s),
        .cu (w_cu)
    );

    assign w_last   = (r_idx == c_LAST);
    assign w_a_sign = r_a[c_NSL-1][N-1];
    // Sign of the effective second operand, after optional inversion.
    assign w_b_sign = r_b[c_NSL-1][N-1] ^ r_op;
    // On the final edge the slice output's MSB is the result sign bit.
    assign w_ovf    = (w_a_sign == w_b_sign) && (w_s[N-1] != w_a_sign);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 1'b0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                // DONE accepts a new request exactly like IDLE, which gives
                // back-to-back operation without an idle cycle.
                c_ST_IDLE, c_ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_op     <= op;
                        r_carry  <= ci;
                        r_idx    <= '0;
                        r_result <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= c_ST_RUN;
                    end else begin
                        r_busy   <= 1'b0;
                        r_state  <= c_ST_IDLE;
                    end
                end

                c_ST_RUN: begin
                    r_result[r_idx] <= w_s;
                    r_carry         <= w_cu;
                    if (w_last) begin
                        r_idx   <= '0;
                        r_cout  <= w_cu;
                        r_ovf   <= w_ovf;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_idx   <= r_idx + c_IW'(1);
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire
